johnson_seq_gen: RTL and testbench

Parametrised twisted-ring (Johnson) or one-hot ring sequence generator.
- Enable, direction control, synchronous clear and runtime mode select.
- Illegal-state self-correction.
- Registered output stage that also provides a decoded phase index and a wrap pulse.
- Used as a multiphase clock-enable and sequencer source.

---
 rtl/johnson_pkg.sv | 24 ++
 rtl/johnson_phase_dec.sv | 49 ++++
 rtl/johnson_seq_gen.sv | 111 +++++++++++
 tb/tb_johnson_seq_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg
// Shared constants and helpers for the Johnson/ring sequencer family.
//   MODE_JOHNSON / MODE_RING : sequence type select encodings
//   DIR_FWD / DIR_REV        : step direction encodings
//   seed(mode, width)        : restart value for a given sequence type
package johnson_pkg;

   localparam logic MODE_JOHNSON = 1'b0;
   localparam logic MODE_RING    = 1'b1;
   localparam logic DIR_FWD      = 1'b0;
   localparam logic DIR_REV      = 1'b1;

   localparam int MAX_WIDTH = 16;

   // Johnson restarts from all zeros, ring from a single one in bit 0.
   // Returned at the widest supported size; callers cast to their width.
   function automatic logic [MAX_WIDTH-1:0] seed(input logic mode, input int width);
      logic [MAX_WIDTH-1:0] s;
      s = '0;
      if (mode == MODE_RING && width > 0) s[0] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/johnson_phase_dec.sv
// johnson_phase_dec
// Combinational phase decoder and legality checker for a Johnson or
// one-hot ring state vector.
//   state : current state bits
//   mode  : sequence type the state is interpreted under
//   p     : phase index of state (meaningful only when legal = 1)
//   legal : state belongs to the sequence of the given mode
module johnson_phase_dec #(
   parameter int WIDTH = 4,
   parameter int PW    = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0] state,
   input  logic             mode,
   output logic [PW-1:0]    p,
   output logic             legal
);

   import johnson_pkg::*;

   always_comb begin
      int ones;
      int edges;
      int idx;
      ones  = 0;
      edges = 0;
      idx   = 0;
      p     = '0;
      legal = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         ones += int'(state[i]);
         if (state[i]) idx = i;
      end
      // A valid Johnson word is a single run of ones against a run of zeros,
      // so it has at most one 0/1 transition between neighbouring bits.
      for (int i = 0; i < WIDTH-1; i++) begin
         if (state[i] != state[i+1]) edges++;
      end
      if (mode == MODE_RING) begin
         legal = (ones == 1);
         p     = PW'(idx);
      end else begin
         legal = (edges <= 1);
         // Filling half counts ones upward; draining half (msb set) counts
         // the remaining ones down from 2*WIDTH.
         p     = state[WIDTH-1] ? PW'(2*WIDTH - ones) : PW'(ones);
      end
   end

endmodule

// File: rtl/johnson_seq_gen.sv
// johnson_seq_gen
// Parametrised Johnson (twisted-ring) or one-hot ring sequence generator with
// illegal-state self-correction and a registered output stage.
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset
//   en    : advance one step this cycle
//   dir   : 0 forward, 1 reverse
//   mode  : 0 Johnson, 1 ring
//   clr   : synchronous clear to the seed of the requested mode
//   q     : registered copy of the state
//   phase : registered phase index of q
//   wrap  : one-cycle pulse with q marking a sequence boundary crossing
//   err   : sticky illegal-state-corrected flag (cleared by clr or reset)
// WIDTH must lie in 2..16; PW is derived and must not be overridden.
module johnson_seq_gen #(
   parameter int WIDTH = 4,
   parameter int PW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             err
);

   import johnson_pkg::*;

   localparam logic [PW-1:0] LAST_JOHNSON = PW'(2*WIDTH - 1);
   localparam logic [PW-1:0] LAST_RING    = PW'(WIDTH - 1);

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] step_nxt;
   logic             mode_r;
   logic             wrap_s;
   logic             legal;
   logic             at_boundary;
   logic             fb_fwd;
   logic             fb_rev;
   logic [PW-1:0]    p;
   logic [PW-1:0]    last;

   johnson_phase_dec #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_dec (
      .state (state),
      .mode  (mode_r),
      .p     (p),
      .legal (legal)
   );

   always_comb begin
      last   = (mode_r == MODE_RING) ? LAST_RING : LAST_JOHNSON;
      // Johnson inverts the bit fed back around the ring; ring passes it through.
      fb_fwd = (mode_r == MODE_RING) ? state[WIDTH-1] : ~state[WIDTH-1];
      fb_rev = (mode_r == MODE_RING) ? state[0]       : ~state[0];
      if (dir == DIR_REV) begin
         step_nxt    = {fb_rev, state[WIDTH-1:1]};
         at_boundary = (p == '0);
      end else begin
         step_nxt    = {state[WIDTH-2:0], fb_fwd};
         at_boundary = (p == last);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= '0;
         mode_r <= MODE_JOHNSON;
         wrap_s <= 1'b0;
         err    <= 1'b0;
         q      <= '0;
         phase  <= '0;
         wrap   <= 1'b0;
      end else begin
         // Output stage: one cycle behind the state register.
         q     <= state;
         phase <= p;
         wrap  <= wrap_s;

         // State stage.
         if (clr) begin
            state  <= WIDTH'(seed(mode, WIDTH));
            err    <= 1'b0;
            wrap_s <= 1'b0;
         end else if (mode != mode_r) begin
            // A mode switch always restarts; reset leaves mode_r at Johnson,
            // so coming out of reset in ring mode lands here, not in the
            // illegal-state branch.
            state  <= WIDTH'(seed(mode, WIDTH));
            mode_r <= mode;
            wrap_s <= 1'b0;
         end else if (!legal) begin
            state  <= WIDTH'(seed(mode_r, WIDTH));
            err    <= 1'b1;
            wrap_s <= 1'b0;
         end else if (en) begin
            state  <= step_nxt;
            wrap_s <= at_boundary;
         end else begin
            wrap_s <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_johnson_seq_gen.sv
module tb_johnson_seq_gen;

   localparam int W  = 4;
   localparam int PW = $clog2(2*W);

   logic          clk = 1'b0;
   logic          n_rst;
   logic          en;
   logic          dir;
   logic          mode;
   logic          clr;
   logic [W-1:0]  q;
   logic [PW-1:0] phase;
   logic          wrap;
   logic          err;

   int total = 0;
   int bad   = 0;

   // Backdoor request: the model treats bd_val as the current state at the next edge.
   logic          bd_pend;
   logic [W-1:0]  bd_val;
   logic          chk_on;

   johnson_seq_gen #(.WIDTH(W)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (en),
      .dir   (dir),
      .mode  (mode),
      .clr   (clr),
      .q     (q),
      .phase (phase),
      .wrap  (wrap),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The sequence is a table of words indexed by phase k; stepping is k +/- 1
   // modulo the sequence length.
   function automatic logic [W-1:0] gen(input logic md, input int k);
      int v;
      if (md) v = 1 << k;
      else if (k <= W) v = (1 << k) - 1;
      else v = ((1 << (2*W - k)) - 1) << (k - W);
      return v[W-1:0];
   endfunction

   function automatic bit lookup(input logic md, input logic [W-1:0] st, output int k);
      int len;
      len = md ? W : 2*W;
      k = 0;
      for (int i = 0; i < len; i++) begin
         if (gen(md, i) == st) begin
            k = i;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] seedv(input logic md);
      return md ? W'(1) : W'(0);
   endfunction

   logic [W-1:0] m_st;
   logic         m_mode_r;
   logic         m_wrap_s;
   logic         m_err;
   logic [W-1:0] o_q;
   int           o_ph;
   logic         o_phk;
   logic         o_wrap;

   always @(posedge clk or negedge n_rst) begin
      logic [W-1:0] cur;
      int           k;
      int           len;
      bit           ok;
      if (!n_rst) begin
         m_st     <= '0;
         m_mode_r <= 1'b0;
         m_wrap_s <= 1'b0;
         m_err    <= 1'b0;
         o_q      <= '0;
         o_ph     <= 0;
         o_phk    <= 1'b1;
         o_wrap   <= 1'b0;
      end else begin
         cur = bd_pend ? bd_val : m_st;
         ok  = lookup(m_mode_r, cur, k);
         len = m_mode_r ? W : 2*W;
         o_q    <= cur;
         o_ph   <= k;
         o_phk  <= ok;
         o_wrap <= m_wrap_s;
         if (clr) begin
            m_st     <= seedv(mode);
            m_err    <= 1'b0;
            m_wrap_s <= 1'b0;
         end else if (mode != m_mode_r) begin
            m_st     <= seedv(mode);
            m_mode_r <= mode;
            m_wrap_s <= 1'b0;
         end else if (!ok) begin
            m_st     <= seedv(m_mode_r);
            m_err    <= 1'b1;
            m_wrap_s <= 1'b0;
         end else if (en) begin
            if (dir) begin
               m_st     <= gen(m_mode_r, (k + len - 1) % len);
               m_wrap_s <= (k == 0);
            end else begin
               m_st     <= gen(m_mode_r, (k + 1) % len);
               m_wrap_s <= (k == len - 1);
            end
         end else begin
            m_wrap_s <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on && n_rst) begin
         chk("m_q", int'(q), int'(o_q));
         if (o_phk) chk("m_phase", int'(phase), o_ph);
         chk("m_wrap", int'(wrap), int'(o_wrap));
         chk("m_err", int'(err), int'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   int t1q[9]    = '{0, 1, 3, 7, 15, 14, 12, 8, 0};
   int t2q[4]    = '{3, 1, 0, 8};
   int t2p[4]    = '{2, 1, 0, 7};
   int t3q[5]    = '{1, 2, 4, 8, 1};
   int t3p[5]    = '{0, 1, 2, 3, 0};
   int t6en[4]   = '{1, 0, 0, 1};

   initial begin
      n_rst   = 1'b0;
      en      = 1'b0;
      dir     = 1'b0;
      mode    = 1'b0;
      clr     = 1'b0;
      bd_pend = 1'b0;
      bd_val  = '0;
      chk_on  = 1'b0;

      #12;
      chk("rst_q", int'(q), 0);
      chk("rst_phase", int'(phase), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_err", int'(err), 0);

      @(negedge clk);
      n_rst  = 1'b1;
      chk_on = 1'b1;

      // 1: forward Johnson run over a full cycle
      en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("t1_q", int'(q), t1q[i]);
         chk("t1_phase", int'(phase), i % 8);
         chk("t1_wrap", int'(wrap), (i == 8) ? 1 : 0);
      end

      // 2: reverse through the boundary from state 0011
      @(negedge clk);
      dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_q", int'(q), t2q[i]);
         chk("t2_phase", int'(phase), t2p[i]);
         chk("t2_wrap", int'(wrap), (i == 3) ? 1 : 0);
      end

      // 3: switch to ring mode from state 0111
      dir = 1'b0;
      en  = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      en  = 1'b1;
      repeat (3) @(negedge clk);
      mode = 1'b1;
      @(negedge clk);
      chk("t3_q_pre", int'(q), 7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_q", int'(q), t3q[i]);
         chk("t3_phase", int'(phase), t3p[i]);
         chk("t3_wrap", int'(wrap), (i == 4) ? 1 : 0);
         chk("t3_err", int'(err), 0);
      end

      // 4: illegal Johnson state corrected even with en low
      mode = 1'b0;
      en   = 1'b0;
      @(negedge clk);
      force dut.state = 4'b0101;
      bd_val  = 4'b0101;
      bd_pend = 1'b1;
      #1 release dut.state;
      @(negedge clk);
      bd_pend = 1'b0;
      chk("t4_q_bad", int'(q), 5);
      chk("t4_err_set", int'(err), 1);
      @(negedge clk);
      chk("t4_q_seed", int'(q), 0);
      chk("t4_err_sticky", int'(err), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("t4_err_clr", int'(err), 0);
      @(negedge clk);
      chk("t4_q_clr", int'(q), 0);

      // 5: clear wins over enable at 1110, then async reset mid-count
      en = 1'b1;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      chk("t5_q_1110", int'(q), 14);
      clr = 1'b0;
      en  = 1'b0;
      @(negedge clk);
      chk("t5_q_nostep", int'(q), 0);
      chk("t5_phase_nostep", int'(phase), 0);
      en = 1'b1;
      repeat (3) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("t5_arst_q", int'(q), 0);
      chk("t5_arst_phase", int'(phase), 0);
      chk("t5_arst_wrap", int'(wrap), 0);
      chk("t5_arst_err", int'(err), 0);
      mode = 1'b1;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t5_ring_seed_q", int'(q), 1);
      chk("t5_ring_seed_err", int'(err), 0);

      // 6: enable toggling back in Johnson mode
      mode = 1'b0;
      en   = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         en = t6en[i];
         @(negedge clk);
      end
      en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_q_two_steps", int'(q), 3);
      chk("t6_wrap_low", int'(wrap), 0);

      // randomized traffic
      repeat (600) begin
         en  = 1'($urandom_range(0, 1));
         dir = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         @(negedge clk);
      end
      en  = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      chk_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
